// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter slice: FSM state encoding,
// the default response timeout and an index-width helper.
package pack;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arbState;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Winner selection: scans the request vector starting at the round-robin
// pointer, or at channel 0 when fixed-priority mode is selected.
module rr_select
    import pack::*;
#(
    parameter int CHANNELS = 2,
    parameter int IDXW     = idxWidth(CHANNELS)
) (
    input  logic [CHANNELS-1:0] request,
    input  logic [IDXW-1:0]     pointer,
    input  logic                fixedMode,
    output logic [CHANNELS-1:0] winnerOneHot,
    output logic [IDXW-1:0]     winnerIndex
);

    int            startPos;
    int            candPos;
    logic [IDXW-1:0] candIdx;
    logic          found;

    always_comb begin
        winnerOneHot = '0;
        winnerIndex  = '0;
        found        = 1'b0;
        candPos      = 0;
        candIdx      = '0;
        startPos     = fixedMode ? 0 : int'(pointer);
        for (int i = 0; i < CHANNELS; i++) begin
            candPos = startPos + i;
            if (candPos >= CHANNELS) begin
                candPos = candPos - CHANNELS;
            end
            candIdx = IDXW'(candPos);
            if (!found && request[candIdx]) begin
                found                 = 1'b1;
                winnerOneHot[candIdx] = 1'b1;
                winnerIndex           = candIdx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel memory arbiter: grants one requester at a time, forwards the
// request downstream and routes the response (or a timeout error) back.
module mem_arbiter
    import pack::*;
#(
    parameter int CHANNELS       = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            reqValid,
    input  logic [CHANNELS-1:0]            reqWrite,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] reqAddress,
    input  logic [CHANNELS*DATA_WIDTH-1:0] reqStoreData,
    input  logic [CHANNELS*DATA_WIDTH/8-1:0] reqByteEnable,
    output logic [CHANNELS-1:0]            reqReady,
    output logic [CHANNELS-1:0]            respValid,
    output logic [DATA_WIDTH-1:0]          respData,
    output logic                           respStoreComplete,
    output logic                           respError,
    output logic                           memValid,
    output logic                           memWrite,
    output logic [ADDR_WIDTH-1:0]          memAddress,
    output logic [DATA_WIDTH-1:0]          memStoreData,
    output logic [DATA_WIDTH/8-1:0]        memByteEnable,
    input  logic                           memReady,
    input  logic                           memRespValid,
    input  logic [DATA_WIDTH-1:0]          memRespData
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDXW     = idxWidth(CHANNELS);
    localparam int CNTW     = $clog2(TIMEOUT_CYCLES + 1);

    logic [ADDR_WIDTH-1:0] chanAddress   [CHANNELS];
    logic [DATA_WIDTH-1:0] chanStoreData [CHANNELS];
    logic [BE_WIDTH-1:0]   chanByteEn    [CHANNELS];

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : gUnpack
        assign chanAddress[gi]   = reqAddress[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign chanStoreData[gi] = reqStoreData[gi*DATA_WIDTH +: DATA_WIDTH];
        assign chanByteEn[gi]    = reqByteEnable[gi*BE_WIDTH +: BE_WIDTH];
    end

    arbState           stateReg;
    logic [IDXW-1:0]   pointerReg;
    logic [IDXW-1:0]   ownerReg;
    logic [CNTW-1:0]   waitCountReg;
    logic [CHANNELS-1:0] winnerOneHot;
    logic [IDXW-1:0]   winnerIndex;
    logic [CHANNELS-1:0] ownerOneHot;
    logic              grantAllowed;

    rr_select #(
        .CHANNELS (CHANNELS),
        .IDXW     (IDXW)
    ) uSelect (
        .request      (reqValid),
        .pointer      (pointerReg),
        .fixedMode    (FIXED_PRIORITY != 0),
        .winnerOneHot (winnerOneHot),
        .winnerIndex  (winnerIndex)
    );

    // No grant while a response pulse is on the bus, and nothing leaks out during reset.
    assign grantAllowed = (stateReg == IDLE) && !reset && (respValid == '0);
    assign reqReady     = grantAllowed ? winnerOneHot : '0;
    assign ownerOneHot  = {{(CHANNELS-1){1'b0}}, 1'b1} << ownerReg;

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg          <= IDLE;
            pointerReg        <= '0;
            ownerReg          <= '0;
            waitCountReg      <= '0;
            respValid         <= '0;
            respData          <= '0;
            respStoreComplete <= 1'b0;
            respError         <= 1'b0;
            memValid          <= 1'b0;
            memWrite          <= 1'b0;
            memAddress        <= '0;
            memStoreData      <= '0;
            memByteEnable     <= '0;
        end else begin
            respValid         <= '0;
            respData          <= '0;
            respStoreComplete <= 1'b0;
            respError         <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (reqReady != '0) begin
                        memValid      <= 1'b1;
                        memWrite      <= reqWrite[winnerIndex];
                        memAddress    <= chanAddress[winnerIndex];
                        memStoreData  <= chanStoreData[winnerIndex];
                        memByteEnable <= chanByteEn[winnerIndex];
                        ownerReg      <= winnerIndex;
                        pointerReg    <= (winnerIndex == IDXW'(CHANNELS - 1)) ? '0
                                         : winnerIndex + IDXW'(1);
                        stateReg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (memReady) begin
                        memValid     <= 1'b0;
                        waitCountReg <= '0;
                        stateReg     <= WAIT;
                    end
                end
                WAIT: begin
                    // A response arriving on the timeout cycle still counts as a normal response.
                    if (memRespValid) begin
                        respValid         <= ownerOneHot;
                        respData          <= memRespData;
                        respStoreComplete <= memWrite;
                        stateReg          <= IDLE;
                    end else if (waitCountReg == CNTW'(TIMEOUT_CYCLES - 1)) begin
                        respValid <= ownerOneHot;
                        respError <= 1'b1;
                        stateReg  <= IDLE;
                    end else begin
                        waitCountReg <= waitCountReg + CNTW'(1);
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter: a round-robin instance with a
// short timeout, plus a fixed-priority instance for the priority scenario.
module tb_mem_arbiter;

    localparam int T = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  reqValid;
    logic [1:0]  reqWrite;
    logic [63:0] reqAddress;
    logic [63:0] reqStoreData;
    logic [7:0]  reqByteEnable;
    logic        memReady;
    logic        memRespValid;
    logic [31:0] memRespData;

    logic [1:0]  reqReady, respValid;
    logic [31:0] respData;
    logic        respStoreComplete, respError;
    logic        memValid, memWrite;
    logic [31:0] memAddress, memStoreData;
    logic [3:0]  memByteEnable;

    logic        memReadyF, memRespValidF;
    logic [31:0] memRespDataF;
    logic [1:0]  reqReadyF, respValidF;
    logic [31:0] respDataF;
    logic        respStoreCompleteF, respErrorF;
    logic        memValidF, memWriteF;
    logic [31:0] memAddressF, memStoreDataF;
    logic [3:0]  memByteEnableF;

    int testsRun = 0;
    int testsFailed = 0;
    int modelPtr = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                  .FIXED_PRIORITY(0), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .reqValid(reqValid), .reqWrite(reqWrite),
        .reqAddress(reqAddress), .reqStoreData(reqStoreData), .reqByteEnable(reqByteEnable),
        .reqReady(reqReady), .respValid(respValid), .respData(respData),
        .respStoreComplete(respStoreComplete), .respError(respError),
        .memValid(memValid), .memWrite(memWrite), .memAddress(memAddress),
        .memStoreData(memStoreData), .memByteEnable(memByteEnable),
        .memReady(memReady), .memRespValid(memRespValid), .memRespData(memRespData)
    );

    mem_arbiter #(.CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                  .FIXED_PRIORITY(1), .TIMEOUT_CYCLES(T)) dutFixed (
        .clock(clock), .reset(reset), .reqValid(reqValid), .reqWrite(reqWrite),
        .reqAddress(reqAddress), .reqStoreData(reqStoreData), .reqByteEnable(reqByteEnable),
        .reqReady(reqReadyF), .respValid(respValidF), .respData(respDataF),
        .respStoreComplete(respStoreCompleteF), .respError(respErrorF),
        .memValid(memValidF), .memWrite(memWriteF), .memAddress(memAddressF),
        .memStoreData(memStoreDataF), .memByteEnable(memByteEnableF),
        .memReady(memReadyF), .memRespValid(memRespValidF), .memRespData(memRespDataF)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".reqReady"}, 64'(reqReady), 0);
        check({tag, ".respValid"}, 64'(respValid), 0);
        check({tag, ".respData"}, 64'(respData), 0);
        check({tag, ".respStoreComplete"}, 64'(respStoreComplete), 0);
        check({tag, ".respError"}, 64'(respError), 0);
        check({tag, ".memValid"}, 64'(memValid), 0);
        check({tag, ".memWrite"}, 64'(memWrite), 0);
        check({tag, ".memAddress"}, 64'(memAddress), 0);
        check({tag, ".memStoreData"}, 64'(memStoreData), 0);
        check({tag, ".memByteEnable"}, 64'(memByteEnable), 0);
    endtask

    task automatic randomFields();
        reqWrite      = 2'($urandom);
        reqAddress    = {$urandom, $urandom};
        reqStoreData  = {$urandom, $urandom};
        reqByteEnable = 8'($urandom);
    endtask

    // Round-robin rule: first requester found scanning upward from the pointer, wrapping.
    function automatic int rrPick(input logic [1:0] v, input int p);
        for (int i = 0; i < 2; i++) begin
            if (v[(p + i) % 2]) return (p + i) % 2;
        end
        return 0;
    endfunction

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // One transaction from a grant-ready IDLE cycle. respDelay < 0 means no response (timeout).
    task automatic runTxn(input logic [1:0] valid, input int issueDelay,
                          input int respDelay, input bit noise);
        int w;
        bit respond;
        int nWait;
        logic [31:0] expAddr, expData, rd;
        logic [3:0] expBe;
        logic expWrite;
        logic [1:0] expOh;
        reqValid = valid;
        memReady = 1'b0;
        memRespValid = noise;
        memRespData = $urandom;
        w = rrPick(valid, modelPtr);
        expOh = 2'b01 << w;
        expAddr = reqAddress[w*32 +: 32];
        expData = reqStoreData[w*32 +: 32];
        expBe = reqByteEnable[w*4 +: 4];
        expWrite = reqWrite[w];
        @(negedge clock);
        check("grant.reqReady", 64'(reqReady), 64'(expOh));
        check("grant.respValid", 64'(respValid), 0);
        $display("[TB] grant ch%0d valid=%b addr=%h write=%0b", w, valid, expAddr, expWrite);
        modelPtr = (w + 1) % 2;
        nextCycle();
        randomFields();
        for (int i = 0; i <= issueDelay; i++) begin
            memReady = (i == issueDelay);
            memRespValid = noise ? 1'($urandom) : 1'b0;
            @(negedge clock);
            check("issue.memValid", 64'(memValid), 1);
            check("issue.memAddress", 64'(memAddress), 64'(expAddr));
            check("issue.memStoreData", 64'(memStoreData), 64'(expData));
            check("issue.memByteEnable", 64'(memByteEnable), 64'(expBe));
            check("issue.memWrite", 64'(memWrite), 64'(expWrite));
            check("issue.reqReady", 64'(reqReady), 0);
            nextCycle();
        end
        memReady = 1'b0;
        respond = (respDelay >= 0) && (respDelay < T);
        nWait = respond ? respDelay + 1 : T;
        rd = $urandom;
        for (int i = 0; i < nWait; i++) begin
            memRespValid = respond && (i == respDelay);
            memRespData = rd;
            @(negedge clock);
            check("wait.memValid", 64'(memValid), 0);
            check("wait.respValid", 64'(respValid), 0);
            nextCycle();
        end
        memRespValid = noise;
        memRespData = $urandom;
        @(negedge clock);
        check("resp.respValid", 64'(respValid), 64'(expOh));
        check("resp.respError", 64'(respError), 64'(!respond));
        check("resp.respData", 64'(respData), respond ? 64'(rd) : 64'(0));
        if (respond) check("resp.storeComplete", 64'(respStoreComplete), 64'(expWrite));
        check("resp.noGrant", 64'(reqReady), 0);
        $display("[TB] resp  ch%0d data=%h err=%0b store=%0b", w, respData, respError,
                 respStoreComplete);
        nextCycle();
        memRespValid = 1'b0;
    endtask

    initial begin
        int cnt0;
        bit seen;
        logic prevMemValidF;
        reset = 1'b1;
        reqValid = 2'b00;
        memReady = 1'b0;
        memRespValid = 1'b0;
        memRespData = '0;
        memReadyF = 1'b1;
        memRespValidF = 1'b0;
        memRespDataF = 32'hA5A5_0000;
        randomFields();
        nextCycle();
        nextCycle();
        reqValid = 2'b11;
        @(negedge clock);
        checkAllZero("reset");
        nextCycle();
        reqValid = 2'b00;
        reset = 1'b0;
        modelPtr = 0;

        // Back-to-back round-robin, minimum latency.
        for (int n = 0; n < 4; n++) runTxn(2'b11, 0, 0, 1'b0);

        // Store from channel 1 with a slow downstream accept.
        reqWrite = 2'b10;
        reqAddress[63:32] = 32'h0000_0100;
        reqByteEnable[7:4] = 4'b0011;
        runTxn(2'b10, 5, 2, 1'b0);

        // Timeout followed by a late response; then a response on the timeout cycle.
        runTxn(2'($urandom_range(1, 3)), 1, -1, 1'b1);
        runTxn(2'($urandom_range(1, 3)), 0, T - 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int k;
            randomFields();
            k = $urandom_range(0, T + 1);
            runTxn(2'($urandom_range(1, 3)), $urandom_range(0, 3),
                   (k >= T) ? -1 : k, 1'($urandom));
        end

        // Reset in WAIT: no response, outputs cleared, pointer back to channel 0.
        runTxn(2'b01, 0, 0, 1'b0);
        reqValid = 2'b01;
        @(negedge clock);
        check("rstWait.grant", 64'(reqReady), 64'(2'b01));
        nextCycle();
        memReady = 1'b1;
        nextCycle();
        memReady = 1'b0;
        nextCycle();
        reset = 1'b1;
        reqValid = 2'b00;
        memRespValid = 1'b1;
        @(negedge clock);
        check("rstWait.respValid", 64'(respValid), 0);
        nextCycle();
        reset = 1'b0;
        memRespValid = 1'b0;
        @(negedge clock);
        checkAllZero("afterReset");
        modelPtr = 0;
        nextCycle();
        runTxn(2'b11, 0, 0, 1'b0);

        // Fixed priority: channel 0 always wins while it requests.
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        memReady = 1'b1;
        memRespValid = 1'b1;
        reqValid = 2'b11;
        prevMemValidF = 1'b0;
        cnt0 = 0;
        for (int c = 0; c < 16; c++) begin
            memRespValidF = prevMemValidF;
            @(negedge clock);
            prevMemValidF = memValidF;
            check("fixed.noCh1", 64'(reqReadyF[1]), 0);
            if (reqReadyF[0]) begin
                cnt0++;
                $display("[TB] fixed grant ch0 (#%0d)", cnt0);
            end
            nextCycle();
        end
        check("fixed.ch0Grants", 64'(cnt0 >= 3), 1);
        reqValid = 2'b10;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            memRespValidF = prevMemValidF;
            @(negedge clock);
            prevMemValidF = memValidF;
            if (reqReadyF == 2'b10) seen = 1'b1;
            nextCycle();
        end
        check("fixed.ch1AfterDrop", 64'(seen), 1);
        $display("[TB] fixed ch1 granted after drop: %0b", seen);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter CHANNELS, default 2: number of requesting ports (>=2, <=8).
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter DATA_WIDTH, default 32: data width; byte-enable width is DATA_WIDTH/8.
REQ-004 Parameter FIXED_PRIORITY, default 0: 0 selects round-robin; 1 selects fixed priority with channel 0 highest.
REQ-005 Parameter TIMEOUT_CYCLES, default 255: maximum wait for a memory response before an error response is returned.
REQ-006 clock  input  1  sole clock; one clock domain; all logic samples on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 reqValid  input  CHANNELS  per-channel request pending.
REQ-009 reqWrite  input  CHANNELS  per-channel store (1) or load (0).
REQ-010 reqAddress  input  CHANNELS*ADDR_WIDTH  per-channel address, flattened, channel 0 in the low bits.
REQ-011 reqStoreData  input  CHANNELS*DATA_WIDTH  per-channel store data, flattened.
REQ-012 reqByteEnable  input  CHANNELS*DATA_WIDTH/8  per-channel byte enables, flattened.
REQ-013 reqReady  output  CHANNELS  one-cycle accept pulse to the granted channel.
REQ-014 respValid  output  CHANNELS  one-cycle response pulse to the owning channel.
REQ-015 respData  output  DATA_WIDTH  load data, shared, qualified by respValid.
REQ-016 respStoreComplete  output  1  response is a store completion.
REQ-017 respError  output  1  response produced by timeout.
REQ-018 memValid, memWrite, memAddress, memStoreData, memByteEnable  output  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  downstream request.
REQ-019 memReady  input  1  downstream accepts the request.
REQ-020 memRespValid, memRespData  input  1/DATA_WIDTH  downstream response.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE and WAIT; one transaction is outstanding at a time.
REQ-022 In IDLE with any reqValid set, the arbiter SHALL select a winner combinationally, assert reqReady[winner] in that same cycle, latch the winner's fields and owner index, and enter ISSUE.
REQ-023 In round-robin mode the search SHALL start at pointer P, and P SHALL become (winner+1) mod CHANNELS on each grant.
REQ-024 In fixed mode the lowest-index requesting channel SHALL win, and P SHALL be ignored.
REQ-025 In ISSUE, memValid SHALL be high with latched fields held stable until the cycle memReady is high, and the FSM SHALL then enter WAIT.
REQ-026 In WAIT, memRespValid SHALL cause the next cycle to pulse respValid[owner] with respData=memRespData, respStoreComplete=latched write, and respError=0; the FSM SHALL then return to IDLE.
REQ-027 The wait counter SHALL clear on entry to WAIT and increment each WAIT cycle; reaching TIMEOUT_CYCLES without memRespValid SHALL pulse respValid[owner] with respError=1 and respData=0, and return to IDLE.
REQ-028 A memRespValid received in IDLE or ISSUE (a late response) SHALL be ignored.
REQ-029 memRespValid and timeout occurring in the same cycle SHALL be treated as a normal response.
REQ-030 Minimum latency SHALL be: grant at t, memValid at t+1, memReady at t+1, memRespValid at t+2, respValid at t+3.
REQ-031 A new grant SHALL NOT occur in the cycle respValid is pulsed; the earliest next grant is the following IDLE cycle.

Reset
REQ-032 Reset SHALL force state IDLE, P=0, counter=0, and every output to 0.
REQ-033 Reset asserted mid-transaction SHALL discard the pending transaction without a response pulse.

Structure
REQ-034 The state enum and TIMEOUT_CYCLES default SHALL reside in the shared package pack.
REQ-035 Winner selection SHALL be a sub-module rr_select (inputs: request vector, pointer, mode; output: one-hot winner and index).

Verification
REQ-036 CHANNELS=2, reqValid=2'b11 held for 4 transactions with memReady=1 and a 1-cycle response -> grants 0,1,0,1, and each respValid arrives at t+3.
REQ-037 FIXED_PRIORITY=1, reqValid=2'b11 held -> every grant goes to channel 0; channel 1 is granted only after reqValid[0] drops.
REQ-038 Store from channel 1 to address 0x100 with byteEnable 4'b0011 and memReady delayed 5 cycles -> memAddress=0x100 stable throughout ISSUE, then respStoreComplete=1 on respValid[1].
REQ-039 TIMEOUT_CYCLES=8 with memRespValid never asserted -> respError=1 and respValid[owner] pulse after 8 WAIT cycles; a late memRespValid is then ignored.
REQ-040 Reset asserted while in WAIT -> no respValid, all outputs 0 the next cycle, and the next grant goes to channel 0.
